// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: FSM states, captured request, counter width.
package dmem_pkg;

  localparam int unsigned WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } stateT;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dmemReqT;

endpackage

// File: rtl/dmem_bank.sv
// Word-addressed storage: synchronous byte-enabled write, combinational read on one index.
module dmem_bank #(
  parameter int unsigned ADDRESS_REAL_WIDTH = 12
) (
  input  logic                          clk,
  input  logic                          wrEn,
  input  logic [3:0]                    be,
  input  logic [ADDRESS_REAL_WIDTH-3:0] index,
  input  logic [31:0]                   wdata,
  output logic [31:0]                   rdata
);

  localparam int unsigned WORDS = 2 ** (ADDRESS_REAL_WIDTH - 2);

  logic [31:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (wrEn) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[index][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[index];

endmodule

// File: rtl/dmem_responder.sv
// Target end of the core's load/store port: one request at a time, programmable wait
// states, response held until consumed.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH         = 32,
  parameter int unsigned ADDRESS_REAL_WIDTH = 12,
  parameter logic [31:0] BASE_ADDR          = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES        = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [3:0]            req_be,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  busy
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_INIT =
    (WAIT_CYCLES == 0) ? '0 : WAIT_CNT_W'(WAIT_CYCLES - 1);

  stateT                 state, nextState;
  logic [WAIT_CNT_W-1:0] waitCnt, nextWaitCnt;
  dmemReqT               reqReg, accReq;
  logic                  doAccess, accErr, inRange;
  logic [31:0]           bankRdata;

  // With zero wait states the access happens on the accept edge, so it must
  // use the live request rather than the not-yet-captured register.
  always_comb begin
    if (state == IDLE) accReq = '{we: req_we, be: req_be, addr: req_addr, wdata: req_wdata};
    else               accReq = reqReg;
  end

  assign inRange = ((accReq.addr - BASE_ADDR) >> ADDRESS_REAL_WIDTH) == '0;
  assign accErr  = (accReq.addr[1:0] != 2'b00) || !inRange;

  dmem_bank #(
    .ADDRESS_REAL_WIDTH(ADDRESS_REAL_WIDTH)
  ) bank (
    .clk  (clk),
    .wrEn (doAccess && accReq.we && !accErr),
    .be   (accReq.be),
    .index(accReq.addr[ADDRESS_REAL_WIDTH-1:2]),
    .wdata(accReq.wdata),
    .rdata(bankRdata)
  );

  always_comb begin
    nextState   = state;
    nextWaitCnt = waitCnt;
    doAccess    = 1'b0;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (WAIT_CYCLES == 0) begin
            doAccess  = 1'b1;
            nextState = RESP;
          end else begin
            nextWaitCnt = WAIT_INIT;
            nextState   = WAIT;
          end
        end
      end
      WAIT: begin
        if (waitCnt == '0) begin
          doAccess  = 1'b1;
          nextState = RESP;
        end else begin
          nextWaitCnt = waitCnt - 1'b1;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      waitCnt    <= '0;
      reqReg     <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state   <= nextState;
      waitCnt <= nextWaitCnt;
      if (state == IDLE && req_valid) reqReg <= accReq;
      if (doAccess) begin
        resp_err   <= accErr;
        resp_rdata <= (accErr || accReq.we) ? '0 : bankRdata;
      end else if (state == RESP && resp_ready) begin
        resp_err   <= 1'b0;
        resp_rdata <= '0;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, hand sequences for back-pressure,
// reset mid-access and zero-wait throughput, then random traffic against a word-array model.
module tb_dmem_responder;

  localparam int unsigned WAIT2 = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid = 0, req_we = 0, resp_ready = 0;
  logic [3:0]  req_be = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, resp_err, busy;
  logic [31:0] resp_rdata;

  logic        req_valid_0 = 0, req_we_0 = 0, resp_ready_0 = 1;
  logic [3:0]  req_be_0 = '0;
  logic [31:0] req_addr_0 = '0, req_wdata_0 = '0;
  logic        req_ready_0, resp_valid_0, resp_err_0, busy_0;
  logic [31:0] resp_rdata_0;

  dmem_responder #(
    .DATA_WIDTH(32), .ADDRESS_REAL_WIDTH(12), .BASE_ADDR(32'h0), .WAIT_CYCLES(WAIT2)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_be(req_be), .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy)
  );

  dmem_responder #(
    .DATA_WIDTH(32), .ADDRESS_REAL_WIDTH(12), .BASE_ADDR(32'h0), .WAIT_CYCLES(0)
  ) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid_0), .req_ready(req_ready_0), .req_we(req_we_0),
    .req_be(req_be_0), .req_addr(req_addr_0), .req_wdata(req_wdata_0),
    .resp_valid(resp_valid_0), .resp_ready(resp_ready_0), .resp_rdata(resp_rdata_0),
    .resp_err(resp_err_0), .busy(busy_0)
  );

  int nChecks = 0;
  int nFails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Behavioural model: a plain word array, byte merge by arithmetic, range rule from the address map.
  logic [31:0] refMem [1024];

  function automatic bit refErr(input logic [31:0] addr);
    return (addr % 4 != 0) || (addr >= 32'h1000);
  endfunction

  function automatic logic [31:0] refMerge(input logic [31:0] old, input logic [31:0] data,
                                           input logic [3:0] be);
    logic [31:0] res = old;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res = (res & ~(32'hFF << (8 * b))) | (data & (32'hFF << (8 * b)));
    end
    return res;
  endfunction

  task automatic xact(input logic we, input logic [3:0] be, input logic [31:0] addr,
                      input logic [31:0] wdata, output logic [31:0] rdata, output logic err);
    int cyc;
    @(negedge clk);
    check("req_ready_idle", req_ready, 1);
    req_valid = 1; req_we = we; req_be = be; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 0;
    req_we = 1'($urandom); req_be = 4'($urandom); req_addr = $urandom; req_wdata = $urandom;
    cyc = 0;
    while (cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (resp_valid) break;
    end
    check("latency", cyc, WAIT2 + 1);
    check("busy_resp", busy, 1);
    rdata = resp_rdata;
    err   = resp_err;
    resp_ready = 1;
    @(posedge clk); #1;
    resp_ready = 0;
    check("busy_after_hs", busy, 0);
  endtask

  task automatic runOp(input logic we, input logic [3:0] be, input logic [31:0] addr,
                       input logic [31:0] wdata);
    logic [31:0] rd, expRd;
    logic        er, expErr;
    expErr = refErr(addr);
    expRd  = (expErr || we) ? 32'h0 : refMem[addr[11:2]];
    if (!expErr && we) refMem[addr[11:2]] = refMerge(refMem[addr[11:2]], wdata, be);
    xact(we, be, addr, wdata, rd, er);
    check("rand_rdata", rd, expRd);
    check("rand_err", {31'b0, er}, {31'b0, expErr});
  endtask

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] expRdata;
    logic        expErr;
  } vecT;

  initial begin
    vecT         vecs[$];
    logic [31:0] rd, hold;
    logic        er;
    int          nResp;

    #5 check("rst_req_ready", req_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_rdata", resp_rdata, 0);
    check("rst_err", resp_err, 0);
    @(negedge clk) rst = 1;

    vecs.push_back('{1, 4'hF, 32'h10,  32'hDEADBEEF, 32'h0,        0});
    vecs.push_back('{0, 4'hF, 32'h10,  32'h0,        32'hDEADBEEF, 0});
    vecs.push_back('{1, 4'hF, 32'h20,  32'h11223344, 32'h0,        0});
    vecs.push_back('{1, 4'h5, 32'h20,  32'hAABBCCDD, 32'h0,        0});
    vecs.push_back('{0, 4'h0, 32'h20,  32'h0,        32'h11BB33DD, 0});
    vecs.push_back('{0, 4'hF, 32'h22,  32'h0,        32'h0,        1});
    vecs.push_back('{1, 4'hF, 32'h0,   32'hCAFEF00D, 32'h0,        0});
    vecs.push_back('{1, 4'hF, 32'h1000, 32'h0BADBAD0, 32'h0,       1});
    vecs.push_back('{0, 4'hF, 32'h0,   32'h0,        32'hCAFEF00D, 0});
    vecs.push_back('{1, 4'h0, 32'h0,   32'hFFFFFFFF, 32'h0,        0});
    vecs.push_back('{0, 4'hF, 32'h0,   32'h0,        32'hCAFEF00D, 0});
    vecs.push_back('{1, 4'hF, 32'hFFC, 32'hA5A5A5A5, 32'h0,        0});
    vecs.push_back('{0, 4'hF, 32'hFFC, 32'h0,        32'hA5A5A5A5, 0});
    vecs.push_back('{0, 4'hF, 32'hFFFFFFFC, 32'h0,   32'h0,        1});
    vecs.push_back('{1, 4'hF, 32'h1001, 32'h1,       32'h0,        1});
    vecs.push_back('{1, 4'hF, 32'h30,  32'h12345678, 32'h0,        0});
    vecs.push_back('{1, 4'hF, 32'h40,  32'h00000077, 32'h0,        0});

    foreach (vecs[i]) begin
      xact(vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wdata, rd, er);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].expRdata);
      check($sformatf("vec%0d_err", i), {31'b0, er}, {31'b0, vecs[i].expErr});
    end

    // Back-pressure: hold the load response of 0x40 for five cycles.
    @(negedge clk);
    req_valid = 1; req_we = 0; req_be = 4'hF; req_addr = 32'h40;
    @(posedge clk); #1 req_valid = 0;
    repeat (WAIT2 + 1) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", resp_valid, 1);
      check("bp_rdata", resp_rdata, 32'h77);
      check("bp_err", resp_err, 0);
      check("bp_req_ready", req_ready, 0);
      check("bp_busy", busy, 1);
      @(negedge clk);
    end
    resp_ready = 1;
    @(posedge clk); #1 resp_ready = 0;
    @(negedge clk);
    check("bp_release_req_ready", req_ready, 1);
    check("bp_release_valid", resp_valid, 0);

    // Reset during WAIT drops the uncommitted store of 0x5 to 0x30.
    req_valid = 1; req_we = 1; req_be = 4'hF; req_addr = 32'h30; req_wdata = 32'h5;
    @(posedge clk); #1 req_valid = 0;
    @(negedge clk);
    check("mid_busy_before_rst", busy, 1);
    rst = 0;
    #1;
    check("mid_rst_req_ready", req_ready, 1);
    check("mid_rst_valid", resp_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_rdata", resp_rdata, 0);
    check("mid_rst_err", resp_err, 0);
    @(negedge clk) rst = 1;
    xact(0, 4'hF, 32'h30, 32'h0, rd, er);
    check("after_rst_load", rd, 32'h12345678);

    // Zero wait states: held request, resp_ready tied high, one response every two cycles.
    @(negedge clk);
    req_valid_0 = 1; req_we_0 = 1; req_be_0 = 4'hF; req_addr_0 = 32'h50; req_wdata_0 = 32'h0F0F1234;
    nResp = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) check("w0_latency", resp_valid_0, 1);
      if (resp_valid_0) begin
        nResp++;
        check("w0_err", resp_err_0, 0);
      end
    end
    check("w0_resp_count", nResp, 10);
    req_we_0 = 0;
    @(negedge clk);
    check("w0_load_valid", resp_valid_0, 1);
    check("w0_load_rdata", resp_rdata_0, 32'h0F0F1234);
    req_valid_0 = 0;

    // Random traffic over words 0x100..0x13C plus stray misaligned / out-of-range addresses.
    for (int w = 0; w < 16; w++) runOp(1, 4'hF, 32'h100 + 4 * w, $urandom);
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      int unsigned sel;
      a   = 32'h100 + 4 * $urandom_range(0, 15);
      sel = $urandom_range(0, 7);
      if (sel == 0) a = a + $urandom_range(1, 3);
      else if (sel == 1) a = 32'h1000 + 4 * $urandom_range(0, 1023);
      runOp(1'($urandom), 4'($urandom), a, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
